// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared constants and types for the alarm/compare scheduler:
//                register addresses, ctrl bit positions, channel state type
//                and the wrap-safe timestamp expiry helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

  localparam int TS_W = 48;

  // Per-channel register offsets (addr[1:0] when addr[4]=0)
  localparam logic [1:0] REG_CMP_LO = 2'b00;
  localparam logic [1:0] REG_CMP_HI = 2'b01;
  localparam logic [1:0] REG_PERIOD = 2'b10;
  localparam logic [1:0] REG_CTRL   = 2'b11;

  // Global register addresses
  localparam logic [4:0] REG_STATUS  = 5'b10000;
  localparam logic [4:0] REG_NOW_LO  = 5'b10001;
  localparam logic [4:0] REG_SNAP_HI = 5'b10010;

  // ctrl bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IEN = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } ch_state_t;

  // now is at or past cmp when the modular difference lies in the lower half-range
  function automatic logic ts_expired(input logic [TS_W-1:0] now_v,
                                      input logic [TS_W-1:0] cmp_v);
    logic [TS_W-1:0] diff;
    diff = now_v - cmp_v;
    return ~diff[TS_W-1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_channel
//  Description : One compare channel: holds cmp/period/ctrl, runs the
//                IDLE/ARMED state machine and flags expiry as fire_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_channel
  import alarm_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [1:0]      sel_i,
  input  logic [31:0]     wr_data_i,
  input  logic [TS_W-1:0] now_i,
  output logic [31:0]     rd_data_o,
  output logic            fire_o,
  output logic            irq_en_o
);

  ch_state_t       state_q;
  logic [TS_W-1:0] cmp_q;
  logic [31:0]     period_q;
  logic [2:0]      ctrl_q;
  logic [TS_W-1:0] cmp_d;

  // A register write to this channel takes priority over its fire evaluation
  assign fire_o   = (state_q == ARMED) && ts_expired(now_i, cmp_q) && !wr_en_i;
  assign irq_en_o = ctrl_q[CTRL_IEN];
  assign cmp_d    = cmp_q + {{(TS_W-32){1'b0}}, period_q};

  // Read-back mux for the four channel registers
  always_comb begin
    rd_data_o = '0;
    case (sel_i)
      REG_CMP_LO: rd_data_o = cmp_q[31:0];
      REG_CMP_HI: rd_data_o = {16'b0, cmp_q[TS_W-1:32]};
      REG_PERIOD: rd_data_o = period_q;
      REG_CTRL:   rd_data_o = {29'b0, ctrl_q};
      default:    rd_data_o = '0;
    endcase
  end

  // Register writes, channel state machine and periodic reload / one-shot disarm
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cmp_q    <= '0;
      period_q <= '0;
      ctrl_q   <= '0;
    end else if (wr_en_i) begin
      case (sel_i)
        REG_CMP_LO: cmp_q[31:0]      <= wr_data_i;
        REG_CMP_HI: cmp_q[TS_W-1:32] <= wr_data_i[15:0];
        REG_PERIOD: period_q         <= wr_data_i;
        REG_CTRL: begin
          ctrl_q  <= wr_data_i[2:0];
          state_q <= wr_data_i[CTRL_EN] ? ARMED : IDLE;
        end
        default: ;
      endcase
    end else if (fire_o) begin
      if (ctrl_q[CTRL_PER]) begin
        cmp_q <= cmp_d;
      end else begin
        ctrl_q[CTRL_EN] <= 1'b0;
        state_q         <= IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_scheduler
//  Description : Multi-channel alarm scheduler on the slot bus. Decodes
//                register accesses, latches per-channel pending flags (W1C),
//                keeps the timebase snapshot and drives the level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            read,
  input  logic            write,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  input  logic [TS_W-1:0] now,
  output logic            irq
);

  logic [N_CH-1:0] pending_q;
  logic [N_CH-1:0] pending_d;
  logic [N_CH-1:0] fire;
  logic [N_CH-1:0] irq_en;
  logic [N_CH-1:0] ch_wr;
  logic [N_CH-1:0] clr;
  logic [15:0]     snap_q;
  logic [31:0]     ch_rd [4];
  logic            wr_strobe;
  logic            chan_wr;

  assign wr_strobe = write && cs;
  assign chan_wr   = wr_strobe && !addr[4];

  // Channel slots beyond N_CH read as zero and have no write enable
  generate
    for (genvar g = 0; g < 4; g++) begin : g_ch
      if (g < N_CH) begin : g_inst
        localparam logic [1:0] C_IDX = 2'(g);
        assign ch_wr[g] = chan_wr && (addr[3:2] == C_IDX);
        alarm_channel u_ch (
          .clk_i     (clk),
          .rst_ni    (reset),
          .wr_en_i   (ch_wr[g]),
          .sel_i     (addr[1:0]),
          .wr_data_i (wr_data),
          .now_i     (now),
          .rd_data_o (ch_rd[g]),
          .fire_o    (fire[g]),
          .irq_en_o  (irq_en[g])
        );
      end else begin : g_absent
        assign ch_rd[g] = '0;
      end
    end
  endgenerate

  // New fires override a same-cycle write-1-to-clear
  assign clr       = (wr_strobe && (addr == REG_STATUS)) ? wr_data[N_CH-1:0] : '0;
  assign pending_d = (pending_q & ~clr) | fire;

  // Pending flags and the upper-half snapshot taken on each now_lo read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      snap_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (read && cs && (addr == REG_NOW_LO)) begin
        snap_q <= now[TS_W-1:32];
      end
    end
  end

  // Combinational read-data mux over channel and global registers
  always_comb begin
    rd_data = '0;
    if (!addr[4]) begin
      rd_data = ch_rd[addr[3:2]];
    end else begin
      case (addr)
        REG_STATUS:  rd_data[N_CH-1:0] = pending_q;
        REG_NOW_LO:  rd_data = now[31:0];
        REG_SNAP_HI: rd_data = {16'b0, snap_q};
        default:     rd_data = '0;
      endcase
    end
  end

  // Interrupt formed from registered state only
  assign irq = |(pending_q & irq_en);

endmodule
`default_nettype wire

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Multi-channel alarm and compare scheduler that sits on the slot bus beside the 48-bit timer core.
- Consumes the timer's live 48-bit count and holds N_CH compare channels, each one-shot or periodic.
- Latches a per-channel pending flag on expiry and raises one level interrupt to the CPU.
- Also provides a tear-free 48-bit snapshot read of the timebase.

Parameters:
N_CH, 4, number of compare channels (legal range 1..4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cs  in  1  slot chip select
read  in  1  slot read strobe
write  in  1  slot write strobe
addr  in  5  register address within the core
wr_data  in  32  write data
rd_data  out  32  read data (combinational mux of registers)
now  in  48  live count from the timer core
irq  out  1  level interrupt

Behaviour:
- Reset (reset=0, asynchronous): every register clears to 0, all channels go to IDLE, and irq=0.
- Register map for channel regs (addr[4]=0; addr[3:2] selects the channel; addresses for ch >= N_CH read 0 and ignore writes):
  - addr[1:0]=00: cmp_lo[31:0], R/W
  - addr[1:0]=01: cmp_hi[15:0] in wr_data[15:0]; reads zero-extended
  - addr[1:0]=10: period[31:0], R/W
  - addr[1:0]=11: ctrl, R/W: bit0 enable, bit1 periodic, bit2 irq_en
- Global registers (addr[4]=1):
  - 10000: status, pending[N_CH-1:0]; write 1 to clear
  - 10001: now_lo; the read returns now[31:0] and latches now[47:32] into snap_hi
  - 10010: snap_hi; reads zero-extended
  - Other addresses read 0 and ignore writes.
- Write strobe: a write takes effect when write && cs, on the rising clk edge.
- Channel FSM:
  - IDLE -> ARMED on a ctrl write with bit0=1.
  - ARMED -> IDLE on a ctrl write with bit0=0.
- Expiry test (wrap-safe): expired = ((now - cmp) mod 2^48)[47]==0, i.e. now is at or past cmp within a half-range window. Late arming still fires on the first evaluated cycle.
- Fire, ARMED and expired at cycle k: pending[ch] is set at the edge ending cycle k, giving a 1-cycle latency.
  - periodic=1: cmp <= cmp + zero-extended period (mod 2^48); channel stays ARMED.
  - periodic=0: enable is cleared and the channel goes to IDLE.
  - period=0 with periodic=1: the channel fires every cycle while now >= cmp. Software avoids this; the block does not guard it.
- Write vs fire, same cycle: a write to any register of a channel suppresses that channel's fire evaluation in that cycle. The write wins.
- Set vs clear, same cycle: a W1C of a pending bit in the same cycle as a new fire on that channel leaves the bit set. Set wins.
- irq = OR over ch of (pending[ch] & irq_en[ch]), formed combinationally from registers only, so it is glitch-free. Clearing irq_en masks the interrupt but keeps pending.
- cmp writes: cmp_lo and cmp_hi are written independently. Software disables the channel before rewriting a 48-bit compare value; the block does not interlock.
- Snapshot: snap_hi updates only on a now_lo read (read && cs). It holds between reads.
- Reset mid-operation: all state is lost immediately, including pending and snapshot, and irq drops asynchronously.

Decomposition:
- Package alarm_pkg:
  - Address constants: REG_CMP_LO, REG_CMP_HI, REG_PERIOD, REG_CTRL, REG_STATUS, REG_NOW_LO, REG_SNAP_HI
  - ctrl bit indices: CTRL_EN, CTRL_PER, CTRL_IEN
  - ch_state_t enum {IDLE, ARMED}
  - TS_W=48
- Sub-module alarm_channel, instantiated N_CH times via generate:
  - Holds cmp, period and ctrl.
  - Contains the FSM and expiry test.
  - Outputs fire and its read data.
- The top level holds address decode, pending/W1C, snapshot, rd_data mux and irq.

Test Plan:
- One-shot:
  - Stimulus: ch0 cmp=0x0000_0000_0064, ctrl=0b101, sweep now 0x60..0x70.
  - Response: pending[0] and irq rise at the edge after now=0x64. ctrl reads 0b100. No second fire.
- Periodic:
  - Stimulus: ch1 cmp=0x100, period=0x10, ctrl=0b111.
  - Response: pending[1] sets at now=0x100, 0x110, 0x120. Between fires, cmp_lo reads 0x110 then 0x120.
- 48-bit wrap:
  - Stimulus: ch2 cmp=0xFFFF_FFFF_FFF0, period=0x20, periodic.
  - Response: fire at now=0xFFFF_FFFF_FFF0. Next cmp is 0x0000_0000_0010, and it fires when now reaches 0x10, not at 0xFFFF_FFFF_FFF8.
- Simultaneous events:
  - Stimulus A: W1C status=0b1 in the same cycle ch0 fires. Response: pending[0] stays 1.
  - Stimulus B: a cmp_lo write to ch0 in its fire cycle. Response: no fire that cycle.
- Snapshot:
  - Stimulus: now=0x0001_FFFF_FFFF, read now_lo, then advance now to 0x0002_0000_0005 and read snap_hi.
  - Response: the now_lo read returns 0xFFFF_FFFF; snap_hi returns 0x0001.
- Reset and mask:
  - Stimulus: with ch0 pending and irq=1, clear irq_en.
  - Response: irq=0 and pending[0]=1.
  - Stimulus: then pulse reset low mid-cycle.
  - Response: irq, pending and all ctrl read 0 immediately.
